// File: rtl/brq_dummy_instr_retire.sv
// rtl/brq_dummy_instr_retire.sv - tracks in-flight dummy instructions and masks their retirement side-effects
// Optional per-type retired-dummy counters are enabled with BRQ_DUMMY_TYPE_CNT_EN.
module brq_dummy_instr_retire #(
   parameter int unsigned Depth = 4,
   parameter int unsigned CntW  = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            id_valid_i,
   input  logic            id_ready_i,
   input  logic [31:0]     id_instr_i,
   input  logic            id_dummy_i,
   input  logic            wb_valid_i,
   input  logic            wb_rf_we_i,
   input  logic            flush_i,
   output logic            rf_we_o,
   output logic            instr_ret_o,
   output logic            wb_dummy_o,
   output logic [1:0]      dummy_type_o,
   output logic [CntW-1:0] dummy_ret_cnt_o,
   output logic            alert_o
`ifdef BRQ_DUMMY_TYPE_CNT_EN
   ,
   output logic [31:0]     dummy_type_cnt_o
`endif
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

   typedef enum logic [1:0] {
      DummyAdd = 2'd0,
      DummyMul = 2'd1,
      DummyDiv = 2'd2,
      DummyAnd = 2'd3
   } dummy_type_e;

   logic [Depth-1:0] dummy_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             empty, full, accept, pop, push;
   logic             overflow, underflow, illegal_dummy;
   logic             dec_legal;
   dummy_type_e      dec_type;
   logic [1:0]       dummy_type_q;
   logic [CntW-1:0]  ret_cnt_q;
   logic             alert_q;
   logic             unused_rs_fields;

   assign unused_rs_fields = ^id_instr_i[24:15];

   assign empty  = (count_q == '0);
   assign full   = (count_q == (AW+1)'(Depth));
   assign accept = id_valid_i & id_ready_i;
   assign pop    = wb_valid_i & ~empty;
   // A pop frees the slot the same-cycle push lands in, so full+push+pop is fine.
   assign push   = accept & (~full | pop);

   assign overflow      = accept & full & ~pop;
   assign underflow     = wb_valid_i & empty;
   assign illegal_dummy = accept & id_dummy_i & ~dec_legal;

   assign wb_dummy_o  = pop & dummy_q[rd_ptr_q];
   assign rf_we_o     = wb_rf_we_i & ~wb_dummy_o;
   assign instr_ret_o = pop & ~wb_dummy_o;

   assign dummy_type_o    = dummy_type_q;
   assign dummy_ret_cnt_o = ret_cnt_q;
   assign alert_o         = alert_q;

   always_comb begin
      dec_legal = 1'b0;
      dec_type  = DummyAdd;
      if (id_instr_i[6:0] == 7'h33 && id_instr_i[11:7] == 5'd0) begin
         unique case ({id_instr_i[31:25], id_instr_i[14:12]})
            10'b0000000_000: begin dec_legal = 1'b1; dec_type = DummyAdd; end
            10'b0000001_000: begin dec_legal = 1'b1; dec_type = DummyMul; end
            10'b0000001_100: begin dec_legal = 1'b1; dec_type = DummyDiv; end
            10'b0000000_111: begin dec_legal = 1'b1; dec_type = DummyAnd; end
            default:         begin dec_legal = 1'b0; dec_type = DummyAdd; end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dummy_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            dummy_q[wr_ptr_q] <= id_dummy_i;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dummy_type_q <= 2'd0;
         ret_cnt_q    <= '0;
         alert_q      <= 1'b0;
      end else begin
         if (accept && id_dummy_i && dec_legal) begin
            dummy_type_q <= dec_type;
         end
         if (wb_dummy_o) begin
            ret_cnt_q <= ret_cnt_q + 1'b1;
         end
         if (overflow || underflow || illegal_dummy) begin
            alert_q <= 1'b1;
         end
      end
   end

`ifdef BRQ_DUMMY_TYPE_CNT_EN
   logic [1:0] type_mem_q [Depth];
   logic [7:0] type_cnt_q [4];
   logic [1:0] push_type;

   // Illegal dummies are tagged with the type that stays visible on dummy_type_o.
   assign push_type = dec_legal ? dec_type : dummy_type_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) type_mem_q[i] <= 2'd0;
         for (int t = 0; t < 4; t++)     type_cnt_q[t] <= 8'd0;
      end else begin
         if (push && !flush_i) begin
            type_mem_q[wr_ptr_q] <= push_type;
         end
         if (wb_dummy_o && type_cnt_q[type_mem_q[rd_ptr_q]] != 8'hFF) begin
            type_cnt_q[type_mem_q[rd_ptr_q]] <= type_cnt_q[type_mem_q[rd_ptr_q]] + 8'd1;
         end
      end
   end

   assign dummy_type_cnt_o = {type_cnt_q[3], type_cnt_q[2], type_cnt_q[1], type_cnt_q[0]};
`endif

endmodule

// File: tb/tb_brq_dummy_instr_retire.sv
// tb/tb_brq_dummy_instr_retire.sv - directed and randomized checks against a queue-based reference model
module tb_brq_dummy_instr_retire;

   localparam int unsigned Depth = 4;
   localparam int unsigned CntW  = 16;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            id_valid_i = 1'b0, id_ready_i = 1'b0, id_dummy_i = 1'b0;
   logic [31:0]     id_instr_i = '0;
   logic            wb_valid_i = 1'b0, wb_rf_we_i = 1'b0, flush_i = 1'b0;
   logic            rf_we_o, instr_ret_o, wb_dummy_o, alert_o;
   logic [1:0]      dummy_type_o;
   logic [CntW-1:0] dummy_ret_cnt_o;

   brq_dummy_instr_retire #(.Depth(Depth), .CntW(CntW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_valid_i(id_valid_i), .id_ready_i(id_ready_i), .id_instr_i(id_instr_i),
      .id_dummy_i(id_dummy_i), .wb_valid_i(wb_valid_i), .wb_rf_we_i(wb_rf_we_i),
      .flush_i(flush_i), .rf_we_o(rf_we_o), .instr_ret_o(instr_ret_o),
      .wb_dummy_o(wb_dummy_o), .dummy_type_o(dummy_type_o),
      .dummy_ret_cnt_o(dummy_ret_cnt_o), .alert_o(alert_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_q[$];
   bit          m_alert;
   logic [1:0]  m_type;
   int unsigned m_cnt;

   logic        obs_rf, obs_ret, obs_wbd, obs_alert;
   logic [1:0]  obs_type;
   logic [31:0] obs_cnt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_decode(input logic [31:0] ins);
      if (ins[6:0] != 7'h33 || ins[11:7] != 5'd0) return -1;
      if (ins[31:25] == 7'd0 && ins[14:12] == 3'd0) return 0;
      if (ins[31:25] == 7'd1 && ins[14:12] == 3'd0) return 1;
      if (ins[31:25] == 7'd1 && ins[14:12] == 3'd4) return 2;
      if (ins[31:25] == 7'd0 && ins[14:12] == 3'd7) return 3;
      return -1;
   endfunction

   function automatic logic [31:0] make_dummy(input int t, input logic [4:0] rs1, input logic [4:0] rs2);
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = (t == 1 || t == 2) ? 7'd1 : 7'd0;
      f3 = (t == 2) ? 3'd4 : (t == 3) ? 3'd7 : 3'd0;
      return {f7, rs2, rs1, f3, 5'd0, 7'h33};
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      {id_valid_i, id_ready_i, id_dummy_i, wb_valid_i, wb_rf_we_i, flush_i} = '0;
      id_instr_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_eq("rst_rf_we", rf_we_o, 0);
      check_eq("rst_ret", instr_ret_o, 0);
      check_eq("rst_wbd", wb_dummy_o, 0);
      check_eq("rst_type", dummy_type_o, 0);
      check_eq("rst_cnt", dummy_ret_cnt_o, 0);
      check_eq("rst_alert", alert_o, 0);
      rst_ni = 1'b1;
      m_q.delete();
      m_alert = 0;
      m_type  = 0;
      m_cnt   = 0;
   endtask

   task automatic step(input logic v, input logic r, input logic [31:0] ins, input logic d,
                       input logic wv, input logic we, input logic fl);
      bit e_wbd, e_rf, e_ret, nonempty;
      int dt;
      @(negedge clk_i);
      id_valid_i = v; id_ready_i = r; id_instr_i = ins; id_dummy_i = d;
      wb_valid_i = wv; wb_rf_we_i = we; flush_i = fl;
      #1;
      nonempty = (m_q.size() > 0);
      e_wbd = wv && nonempty && m_q[0];
      e_rf  = we && !e_wbd;
      e_ret = wv && nonempty && !e_wbd;
      obs_rf = rf_we_o; obs_ret = instr_ret_o; obs_wbd = wb_dummy_o;
      obs_alert = alert_o; obs_type = dummy_type_o; obs_cnt = 32'(dummy_ret_cnt_o);
      check_eq("wb_dummy", obs_wbd, e_wbd);
      check_eq("rf_we", obs_rf, e_rf);
      check_eq("instr_ret", obs_ret, e_ret);
      check_eq("alert", obs_alert, m_alert);
      check_eq("type", obs_type, m_type);
      check_eq("ret_cnt", obs_cnt, m_cnt);
      @(posedge clk_i);
      if (wv && !nonempty) m_alert = 1;
      if (v && r && d) begin
         dt = model_decode(ins);
         if (dt < 0) m_alert = 1;
         else m_type = 2'(dt);
      end
      if (v && r && m_q.size() == Depth && !wv) m_alert = 1;
      if (e_wbd) m_cnt = (m_cnt + 1) % (1 << CntW);
      if (fl) m_q.delete();
      else begin
         if (wv && nonempty) void'(m_q.pop_front());
         if (v && r && m_q.size() < Depth) m_q.push_back(d);
      end
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 0, 0);
   endtask

   int ret_pulses;
   logic [3:0] wbd_pat;

   initial begin
      m_alert = 0; m_type = 0; m_cnt = 0;

      // Plain instruction retires normally
      do_reset();
      step(1, 1, 32'h00B50533, 0, 0, 0, 0);
      step(0, 0, 32'h0, 0, 1, 1, 0);
      check_eq("t1_rf_we", obs_rf, 1);
      check_eq("t1_ret", obs_ret, 1);
      check_eq("t1_wbd", obs_wbd, 0);
      check_eq("t1_cnt", obs_cnt, 0);

      // DIV dummy is masked at retirement
      step(1, 1, 32'h02C5C033, 1, 0, 0, 0);
      step(0, 0, 32'h0, 0, 1, 1, 0);
      check_eq("t2_type", obs_type, 2);
      check_eq("t2_rf_we", obs_rf, 0);
      check_eq("t2_ret", obs_ret, 0);
      check_eq("t2_wbd", obs_wbd, 1);
      idle();
      check_eq("t2_cnt", obs_cnt, 1);

      // Illegal dummy (rd != 0) raises a sticky alert
      do_reset();
      step(1, 1, 32'h00C580B3, 1, 0, 0, 0);
      idle();
      check_eq("t3_alert", obs_alert, 1);
      step(0, 0, 32'h0, 0, 0, 0, 1);
      repeat (10) idle();
      check_eq("t3_alert_sticky", obs_alert, 1);

      // D,N,D,N ordering
      do_reset();
      step(1, 1, 32'h00B50033, 1, 0, 0, 0);
      step(1, 1, 32'h00B50533, 0, 0, 0, 0);
      step(1, 1, 32'h00B50033, 1, 0, 0, 0);
      step(1, 1, 32'h00B50533, 0, 0, 0, 0);
      ret_pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 32'h0, 0, 1, 1, 0);
         wbd_pat[i] = obs_wbd;
         ret_pulses += int'(obs_ret);
      end
      check_eq("t4_pattern", wbd_pat, 4'b0101);
      check_eq("t4_ret_pulses", ret_pulses, 2);
      idle();
      check_eq("t4_cnt", obs_cnt, 2);
      check_eq("t4_alert", obs_alert, 0);

      // Full FIFO: push+pop is fine, push alone overflows
      do_reset();
      for (int i = 0; i < Depth; i++) step(1, 1, 32'h00B50533, 0, 0, 0, 0);
      step(1, 1, 32'h00B50533, 0, 1, 0, 0);
      idle();
      check_eq("t5_no_alert", obs_alert, 0);
      step(1, 1, 32'h00B50533, 0, 0, 0, 0);
      idle();
      check_eq("t5_overflow", obs_alert, 1);

      // Flush then retire is an underflow
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 32'h00B50533, 0, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 0, 1);
      step(0, 0, 32'h0, 0, 1, 1, 0);
      check_eq("t6_ret", obs_ret, 0);
      idle();
      check_eq("t6_underflow", obs_alert, 1);

      // Randomized traffic, reset periodically so the sticky alert doesn't mask everything
      for (int blk = 0; blk < 10; blk++) begin
         do_reset();
         for (int c = 0; c < 200; c++) begin
            logic v, r, d, wv, we, fl;
            logic [31:0] ins;
            v  = ($urandom % 4) != 0;
            r  = ($urandom % 4) != 0;
            d  = ($urandom % 3) == 0;
            wv = (m_q.size() > 0) ? (($urandom % 10) < 6) : (($urandom % 40) == 0);
            we = $urandom % 2;
            fl = ($urandom % 50) == 0;
            if (d) begin
               ins = make_dummy(int'($urandom % 4), 5'($urandom), 5'($urandom));
               if (($urandom % 40) == 0) ins = ins ^ (32'h1 << ($urandom % 32));
            end else begin
               ins = $urandom;
            end
            step(v, r, ins, d, wv, we, fl);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
